axi_test_sequencer: RTL and testbench
=====================================

// Module: axi_test_sequencer
// PURPOSE
//  Upstream controller for the single-beat AXI test master. It issues N back-to-back
//  write/read-back tests at base_addr, base_addr+ADDR_STRIDE, ... by pulsing the master's
//  start/base_address inputs. It snoops the master's R channel to score each read-back
//  against the master's data pattern, and reports pass/fail counts, first failing address
//  and timeout.
// PARAMETERS
//  ADDR_WIDTH     32    address width; matches master
//  DATA_WIDTH     32    data width; matches master
//  CNT_WIDTH      8     width of num_tests and of the pass/fail counters
//  ADDR_STRIDE    4     byte increment between tests
//  TIMEOUT_CYCLES 1024  max cycles in WAIT per test before abort
// PORTS
//  ACLK             in   1           clock
//  ARESETN          in   1           asynchronous active-low reset
//  run              in   1           start sequence; sampled in IDLE only
//  num_tests        in   CNT_WIDTH   tests to run; sampled with run
//  base_addr        in   ADDR_WIDTH  first test address; sampled with run
//  mst_start        out  1           to master start; 1-cycle pulse
//  mst_base_address out  ADDR_WIDTH  to master base_address; valid while mst_start=1
//  mst_busy         in   1           from master busy
//  mst_done         in   1           from master done (1-cycle pulse)
//  mon_rvalid       in   1           snoop of master RVALID
//  mon_rready       in   1           snoop of master RREADY
//  mon_rdata        in   DATA_WIDTH  snoop of master RDATA
//  seq_busy         out  1           sequence in progress
//  seq_done         out  1           1-cycle pulse at sequence end
//  pass_count       out  CNT_WIDTH   passing tests; saturates at all-ones
//  fail_count       out  CNT_WIDTH   failing tests; saturates at all-ones
//  first_fail_addr  out  ADDR_WIDTH  address of the first failure; 0 if none
//  timeout          out  1           sticky; set when a test hits TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal counters 0. All outputs are registered.
//  - FSM: IDLE -> ISSUE -> WAIT -> CHECK -> (ISSUE | FINISH) -> IDLE.
//  - IDLE: seq_busy=0. On run=1: latch num_tests and base_addr, clear pass/fail,
//    first_fail_addr and timeout, set seq_busy=1. If num_tests==0, go to FINISH;
//    otherwise go to ISSUE. run is ignored in every other state.
//  - ISSUE: if mst_busy=0, drive mst_start=1 with mst_base_address=cur_addr for exactly
//    one cycle, clear rd_seen and the watchdog, then go to WAIT. If mst_busy=1, stay
//    in ISSUE with mst_start=0.
//  - WAIT: on the first cycle with mon_rvalid&mon_rready, capture mon_rdata and set
//    rd_seen. Later handshakes are ignored.
//    mst_done=1 -> CHECK. A handshake in the same cycle as mst_done is still captured.
//    If the watchdog reaches TIMEOUT_CYCLES-1 with no done: fail++, set timeout,
//    record first_fail_addr if it is the first failure, go to FINISH (abort).
//  - CHECK (1 cycle): expected = (32'hA5A5_0000 + cur_addr[15:0]) resized to DATA_WIDTH
//    (zero-extend or truncate). pass iff rd_seen && captured == expected; otherwise
//    fail, and first_fail_addr <= cur_addr if no failure has been recorded yet.
//    Then cur_addr += ADDR_STRIDE (wraps mod 2^ADDR_WIDTH) and idx++.
//    If idx+1 == num_tests go to FINISH, else go to ISSUE.
//  - FINISH (1 cycle): seq_done=1, seq_busy=0, go to IDLE. Counts hold until the next run.
//  - Latency: run to first mst_start is 2 cycles when the master is idle.
//  - Async reset mid-sequence aborts immediately to IDLE. Results are lost; the
//    master is not affected.
// CONFIGURATION
//  - SEQ_RRESP_CHECK_EN defined: adds port mon_rresp (in, 2) and captures it with rdata.
//    CHECK also fails a test if the captured rresp != 2'b00 (OKAY).
//  - Not defined: no mon_rresp port; the response code is not checked.
// STRUCTURE
//  - Package axi_test_pkg holds the state encoding (IDLE..FINISH), the TEST_PATTERN
//    constant 32'hA5A5_0000, RESP_OKAY/EXOKAY/SLVERR/DECERR, and the function
//    exp_data(addr) shared with the master and the benches.
//  - Sub-module seq_watchdog holds the WAIT-cycle counter: inputs clr/en, output expired.
// TESTING
//  - run, num_tests=1, base=0x100, ideal slave -> one mst_start with addr 0x100;
//    rdata 0xA5A5_0100; pass=1, fail=0, seq_done pulse.
//  - num_tests=4, base=0x0, stride 4 -> mst_start addrs 0x0, 0x4, 0x8, 0xC; pass=4;
//    seq_busy high throughout.
//  - Slave corrupts the read at 0x8 -> fail=1, pass=3, first_fail_addr=0x8.
//  - num_tests=0 -> no mst_start; seq_done two cycles after run; counts 0.
//  - Slave never asserts bvalid -> timeout=1, fail=1, seq_done after TIMEOUT_CYCLES.
//  - base=0xFFFF_FFFC, num_tests=2 -> second addr wraps to 0x0.
//    Additionally, ARESETN pulsed low mid-WAIT -> all outputs return to 0.

Source files
------------

// File: rtl/axi_test_pkg.sv
// Shared definitions for the AXI test master, its sequencer and the benches.
package axi_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    localparam logic [31:0] TEST_PATTERN = 32'hA5A5_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Data word the master writes at a given address (low 16 address bits folded in).
    function automatic logic [31:0] exp_data(input logic [15:0] addr_lo);
        return TEST_PATTERN + {16'h0000, addr_lo};
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-phase watchdog: loads TIMEOUT_CYCLES-1 on clr, counts down while en,
// expired once the terminal count (zero) is reached.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = LOAD;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/axi_test_sequencer.sv
// Runs N write/read-back tests through the single-beat AXI test master and scores them.
// Optional SEQ_RRESP_CHECK_EN adds mon_rresp and fails tests whose response is not OKAY.
module axi_test_sequencer
    import axi_test_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned ADDR_STRIDE    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  run,
    input  logic [CNT_WIDTH-1:0]  num_tests,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mst_start,
    output logic [ADDR_WIDTH-1:0] mst_base_address,
    input  logic                  mst_busy,
    input  logic                  mst_done,
    input  logic                  mon_rvalid,
    input  logic                  mon_rready,
    input  logic [DATA_WIDTH-1:0] mon_rdata,
`ifdef SEQ_RRESP_CHECK_EN
    input  logic [1:0]            mon_rresp,
`endif
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  timeout
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(ADDR_STRIDE);

    seq_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, ffa_q, ffa_d, mst_addr_q, mst_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_seen_q, rd_seen_d, timeout_q, timeout_d;
    logic                  busy_q, busy_d, done_q, done_d, start_q, start_d;
    logic                  wd_clr, wd_en, wd_expired;
    logic                  resp_ok, test_ok;
    logic [DATA_WIDTH-1:0] exp_word;

`ifdef SEQ_RRESP_CHECK_EN
    logic [1:0] rresp_q, rresp_d;
    assign resp_ok = (rresp_q == RESP_OKAY);
`else
    assign resp_ok = 1'b1;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign exp_word = DATA_WIDTH'(exp_data(16'(cur_addr_q)));
    assign test_ok  = rd_seen_q && (rdata_q == exp_word) && resp_ok;

    seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        cur_addr_d = cur_addr_q;
        ffa_d      = ffa_q;
        mst_addr_d = mst_addr_q;
        rdata_d    = rdata_q;
        rd_seen_d  = rd_seen_q;
        timeout_d  = timeout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_d    = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
`ifdef SEQ_RRESP_CHECK_EN
        rresp_d    = rresp_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    num_d      = num_tests;
                    cur_addr_d = base_addr;
                    idx_d      = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    ffa_d      = '0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (num_tests == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mst_busy) begin
                    start_d    = 1'b1;
                    mst_addr_d = cur_addr_q;
                    rd_seen_d  = 1'b0;
                    wd_clr     = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // Only the first read-back beat of a test is scored.
                if (mon_rvalid && mon_rready && !rd_seen_q) begin
                    rd_seen_d = 1'b1;
                    rdata_d   = mon_rdata;
`ifdef SEQ_RRESP_CHECK_EN
                    rresp_d   = mon_rresp;
`endif
                end
                if (mst_done) begin
                    state_d = ST_CHECK;
                end else if (wd_expired) begin
                    fail_d    = sat_inc(fail_q);
                    timeout_d = 1'b1;
                    if (fail_q == '0)
                        ffa_d = cur_addr_q;
                    state_d   = ST_FINISH;
                end
            end
            ST_CHECK: begin
                if (test_ok) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    if (fail_q == '0)
                        ffa_d = cur_addr_q;
                end
                cur_addr_d = cur_addr_q + STRIDE;
                idx_d      = idx_q + CNT_ONE;
                state_d    = ((idx_q + CNT_ONE) == num_q) ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            cur_addr_q <= '0;
            ffa_q      <= '0;
            mst_addr_q <= '0;
            rdata_q    <= '0;
            rd_seen_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
`ifdef SEQ_RRESP_CHECK_EN
            rresp_q    <= RESP_OKAY;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            cur_addr_q <= cur_addr_d;
            ffa_q      <= ffa_d;
            mst_addr_q <= mst_addr_d;
            rdata_q    <= rdata_d;
            rd_seen_q  <= rd_seen_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
`ifdef SEQ_RRESP_CHECK_EN
            rresp_q    <= rresp_d;
`endif
        end
    end

    assign mst_start        = start_q;
    assign mst_base_address = mst_addr_q;
    assign seq_busy         = busy_q;
    assign seq_done         = done_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_addr  = ffa_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_axi_test_sequencer.sv
// Scoreboard bench for axi_test_sequencer: a scripted slave model answers each
// mst_start, expected start addresses and end-of-sequence results are queued and checked by a monitor.
module tb_axi_test_sequencer;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int CW     = 8;
    localparam int STRIDE = 4;
    localparam int TO     = 32;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          run = 1'b0;
    logic [CW-1:0] num_tests = '0;
    logic [AW-1:0] base_addr = '0;
    logic          mst_start;
    logic [AW-1:0] mst_base_address;
    logic          mst_busy = 1'b0;
    logic          mst_done = 1'b0;
    logic          mon_rvalid = 1'b0;
    logic          mon_rready = 1'b0;
    logic [DW-1:0] mon_rdata = '0;
    logic          seq_busy, seq_done, timeout;
    logic [CW-1:0] pass_count, fail_count;
    logic [AW-1:0] first_fail_addr;

    always #5 ACLK = ~ACLK;

    axi_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
        .ADDR_STRIDE(STRIDE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .run(run), .num_tests(num_tests),
        .base_addr(base_addr), .mst_start(mst_start), .mst_base_address(mst_base_address),
        .mst_busy(mst_busy), .mst_done(mst_done), .mon_rvalid(mon_rvalid),
        .mon_rready(mon_rready), .mon_rdata(mon_rdata), .seq_busy(seq_busy),
        .seq_done(seq_done), .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr), .timeout(timeout)
    );

    typedef struct {
        logic [CW-1:0] pass;
        logic [CW-1:0] fail;
        logic [AW-1:0] ffa;
        logic          to;
    } res_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [AW-1:0] start_q[$];
    res_t          res_q[$];
    int            starts_seen = 0;
    int            first_start_cyc = 0;
    int            mode = 0;
    logic [AW-1:0] bad_lo = 32'd1;
    logic [AW-1:0] bad_hi = 32'd0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: mode 0 = normal (plus an ignored second beat and a busy stall),
    // mode 1 = read beat coincides with done, mode 2 = never signals done.
    task automatic slave_txn(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = 32'hA5A5_0000 | {16'h0000, a[15:0]};
        if (a >= bad_lo && a <= bad_hi) d = d ^ 32'h0000_1000;
        mst_busy = 1'b1;
        @(negedge ACLK);
        if (mode == 2) begin
            @(negedge ACLK);
            mst_busy = 1'b0;
            return;
        end
        mon_rvalid = 1'b1;
        mon_rready = 1'b1;
        mon_rdata  = d;
        if (mode == 1) begin
            mst_done = 1'b1;
            @(negedge ACLK);
            mon_rvalid = 1'b0;
            mon_rready = 1'b0;
            mst_done   = 1'b0;
            mst_busy   = 1'b0;
            return;
        end
        @(negedge ACLK);
        mon_rdata = 32'hDEAD_BEEF;
        @(negedge ACLK);
        mon_rvalid = 1'b0;
        mon_rready = 1'b0;
        mst_done   = 1'b1;
        @(negedge ACLK);
        mst_done = 1'b0;
        repeat (2) @(negedge ACLK);
        mst_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN && mst_start) slave_txn(mst_base_address);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a start or a done.
    initial begin
        logic [AW-1:0] ea;
        res_t          r;
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (mst_start) begin
                    if (starts_seen == 0) first_start_cyc = cyc;
                    starts_seen++;
                    if (start_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start: got addr 0x%0h expected none", mst_base_address);
                    end else begin
                        ea = start_q.pop_front();
                        check("start_addr", 64'(mst_base_address), 64'(ea));
                    end
                    check("busy_at_start", 64'(seq_busy), 64'd1);
                end
                if (seq_done) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got seq_done expected none");
                    end else begin
                        r = res_q.pop_front();
                        check("pass_count", 64'(pass_count), 64'(r.pass));
                        check("fail_count", 64'(fail_count), 64'(r.fail));
                        check("first_fail_addr", 64'(first_fail_addr), 64'(r.ffa));
                        check("timeout", 64'(timeout), 64'(r.to));
                        check("busy_at_done", 64'(seq_busy), 64'd0);
                    end
                end
            end
        end
    end

    task automatic run_seq(input int n, input logic [AW-1:0] base, input int md, input int n_starts,
                           input logic [CW-1:0] ep, input logic [CW-1:0] ef,
                           input logic [AW-1:0] effa, input logic eto, input bit poke,
                           output int rc, output int dc);
        res_t r;
        bit   got, dropped;
        mode = md;
        for (int i = 0; i < n_starts; i++) start_q.push_back(base + 32'(i * STRIDE));
        r.pass = ep; r.fail = ef; r.ffa = effa; r.to = eto;
        res_q.push_back(r);
        starts_seen = 0;
        got = 1'b0;
        dropped = 1'b0;
        dc = 0;
        @(posedge ACLK); #1;
        run = 1'b1; num_tests = CW'(n); base_addr = base; rc = cyc;
        @(posedge ACLK); #1;
        run = 1'b0; num_tests = 8'd1; base_addr = 32'h5555_0000;
        for (int k = 0; k < 3000; k++) begin
            @(negedge ACLK);
            if (seq_done) begin
                got = 1'b1;
                dc = cyc;
                break;
            end
            if (!seq_busy) dropped = 1'b1;
            if (poke && k == 6) begin
                run = 1'b1; num_tests = 8'd1; base_addr = 32'h0000_0999;
            end
            if (poke && k == 7) run = 1'b0;
        end
        check("seq_done_seen", 64'(got), 64'd1);
        check("busy_held", 64'(dropped), 64'd0);
        repeat (8) @(negedge ACLK);
        check("starts_left", 64'(start_q.size()), 64'd0);
        start_q.delete();
    endtask

    initial begin
        int rc, dc;
        #1;
        check("rst_start", 64'(mst_start), 64'd0);
        check("rst_addr", 64'(mst_base_address), 64'd0);
        check("rst_busy", 64'(seq_busy), 64'd0);
        check("rst_done", 64'(seq_done), 64'd0);
        check("rst_pass", 64'(pass_count), 64'd0);
        check("rst_fail", 64'(fail_count), 64'd0);
        check("rst_ffa", 64'(first_fail_addr), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        #22 ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        run_seq(1, 32'h100, 0, 1, 8'd1, 8'd0, 32'h0, 1'b0, 1'b0, rc, dc);
        check("start_latency", 64'(first_start_cyc - rc), 64'd2);

        run_seq(4, 32'h0, 0, 4, 8'd4, 8'd0, 32'h0, 1'b0, 1'b1, rc, dc);

        bad_lo = 32'h8; bad_hi = 32'h8;
        run_seq(4, 32'h0, 0, 4, 8'd3, 8'd1, 32'h8, 1'b0, 1'b0, rc, dc);
        bad_lo = 32'h8; bad_hi = 32'hC;
        run_seq(4, 32'h0, 0, 4, 8'd2, 8'd2, 32'h8, 1'b0, 1'b0, rc, dc);
        bad_lo = 32'd1; bad_hi = 32'd0;

        run_seq(0, 32'h700, 0, 0, 8'd0, 8'd0, 32'h0, 1'b0, 1'b0, rc, dc);
        check("done_latency_n0", 64'(dc - rc), 64'd2);
        check("starts_n0", 64'(starts_seen), 64'd0);

        run_seq(2, 32'hFFFF_FFFC, 1, 2, 8'd2, 8'd0, 32'h0, 1'b0, 1'b0, rc, dc);

        run_seq(3, 32'h40, 2, 1, 8'd0, 8'd1, 32'h40, 1'b1, 1'b0, rc, dc);
        check("timeout_duration", 64'(dc - first_start_cyc), 64'(TO + 1));

        run_seq(1, 32'h200, 0, 1, 8'd1, 8'd0, 32'h0, 1'b0, 1'b0, rc, dc);

        mode = 0;
        start_q.push_back(32'h300);
        @(posedge ACLK); #1;
        run = 1'b1; num_tests = 8'd2; base_addr = 32'h300;
        @(posedge ACLK); #1;
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (mst_start) break;
        end
        repeat (2) @(negedge ACLK);
        #1 ARESETN = 1'b0;
        #1;
        check("arst_start", 64'(mst_start), 64'd0);
        check("arst_addr", 64'(mst_base_address), 64'd0);
        check("arst_busy", 64'(seq_busy), 64'd0);
        check("arst_done", 64'(seq_done), 64'd0);
        check("arst_pass", 64'(pass_count), 64'd0);
        check("arst_fail", 64'(fail_count), 64'd0);
        check("arst_ffa", 64'(first_fail_addr), 64'd0);
        check("arst_timeout", 64'(timeout), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (10) @(negedge ACLK);
        check("arst_starts_left", 64'(start_q.size()), 64'd0);
        start_q.delete();

        run_seq(1, 32'h10, 1, 1, 8'd1, 8'd0, 32'h0, 1'b0, 1'b0, rc, dc);

        check("results_left", 64'(res_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
